// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between EX (port 0) and branch/address unit (port 1).
// One-cycle grant-to-response latency; a full response register with rsp_ready=0 blocks all grants.
module alu_share_arbiter #(
    parameter int WIDTH     = 16,
    parameter int OPW       = 4,
    parameter int STATW     = 4,
    parameter bit FIRST_PRI = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [OPW-1:0]   op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [OPW-1:0]   op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt1,
    output logic [OPW-1:0]   alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [STATW-1:0] alu_stat,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [STATW-1:0] rsp_stat,
    input  logic             rsp_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} rsp_state_e;

    rsp_state_e state_q, state_d;
    logic       pri_q;
    logic       sel_q;
    logic       sel;
    logic       can_issue;
    logic       any_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (any_gnt) state_d = FULL;
            FULL:  if (rsp_ready && !any_gnt) state_d = EMPTY;
        endcase
    end

    // A held result can be consumed and replaced in the same cycle.
    always_comb begin
        rsp_valid = (state_q == FULL);
        can_issue = (state_q == EMPTY) || rsp_ready;
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && can_issue) begin
            if (req0 && (!req1 || !pri_q)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign any_gnt = gnt0 | gnt1;

    // Without a grant the ALU keeps looking at the last winner's port.
    assign sel      = gnt1 | (sel_q & ~gnt0);
    assign alu_ctrl = sel ? op1 : op0;
    assign alu_a    = sel ? a1  : a0;
    assign alu_b    = sel ? b1  : b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q    <= FIRST_PRI;
            sel_q    <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            rsp_stat <= '0;
        end else begin
            sel_q <= sel;
            if (any_gnt) begin
                pri_q    <= ~gnt1;
                rsp_id   <= gnt1;
                rsp_data <= alu_out;
                rsp_stat <= alu_stat;
            end
        end
    end

endmodule
